// File: rtl/dcmac_rx_pkg.sv
// Shared types and constants for the DCMAC rx segment buffer: lane FSM states,
// tuser bit positions, terminator-beat encoding and the mty-to-tkeep helper.
package dcmac_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_TRUNC
    } lane_state_e;

    localparam int TUSER_ENA = 0;
    localparam int TUSER_SOP = 1;
    localparam int TUSER_ERR = 2;
    localparam int TUSER_W   = 3;

    // Terminator beat closes a truncated packet: no data, error flagged, last.
    localparam logic [TUSER_W-1:0] TERM_TUSER = 3'b101;
    localparam logic               TERM_TLAST = 1'b1;

    localparam int MAX_SEG_BYTES = 256;

    // Low (seg_bytes - mty) bits set; callers cast the result down to their segment width.
    function automatic logic [MAX_SEG_BYTES-1:0] mty_to_tkeep(input int seg_bytes, input int mty);
        logic [MAX_SEG_BYTES-1:0] keep;
        keep = '0;
        for (int b = 0; b < MAX_SEG_BYTES; b++) begin
            keep[b] = (b < seg_bytes - mty);
        end
        return keep;
    endfunction

endpackage

// File: rtl/dcmac_rx_lane.sv
// One rx lane: packet-aware admission FSM in front of a first-word fall-through
// FIFO with occupancy count. Emits one-cycle increment pulses for the statistics.
module dcmac_rx_lane
    import dcmac_rx_pkg::*;
#(
    parameter int SEG_BYTES   = 16,
    parameter int FIFO_DEPTH  = 512,
    parameter int DROP_MARGIN = 8,
    localparam int MW         = $clog2(SEG_BYTES),
    localparam int DW         = SEG_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 beat,
    input  logic [DW-1:0]        data,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 err,
    input  logic [MW-1:0]        mty,
    output logic [DW-1:0]        m_tdata,
    output logic [SEG_BYTES-1:0] m_tkeep,
    output logic [TUSER_W-1:0]   m_tuser,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 drop_inc,
    output logic                 trunc_inc,
    output logic                 orphan_inc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DW-1:0]        data;
        logic [SEG_BYTES-1:0] keep;
        logic [TUSER_W-1:0]   user;
        logic                 last;
    } word_t;

    localparam word_t TERM_WORD = {{(DW + SEG_BYTES){1'b0}}, TERM_TUSER, TERM_TLAST};

    word_t             mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, free;
    logic              full, has_room, rd_en;
    lane_state_e       state, state_nxt;
    logic              pend_eop, pend_nxt;
    logic              wr_en;
    word_t             wr_word, beat_word, rd_word;
    logic [SEG_BYTES-1:0] beat_keep;
    logic [TUSER_W-1:0]   beat_user;

    assign beat_keep            = SEG_BYTES'(mty_to_tkeep(SEG_BYTES, int'(mty)));
    assign beat_user[TUSER_ERR] = err;
    assign beat_user[TUSER_SOP] = sop;
    assign beat_user[TUSER_ENA] = 1'b1;
    assign beat_word            = {data, beat_keep, beat_user, eop};

    // Space is judged on the registered count only, so a read in the same cycle never frees a slot.
    assign free     = CW'(FIFO_DEPTH) - count;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign has_room = (free >= CW'(DROP_MARGIN));

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend_eop;
        wr_en      = 1'b0;
        wr_word    = beat_word;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        orphan_inc = 1'b0;
        unique case (state)
            ST_IDLE: if (beat) begin
                if (sop) begin
                    if (has_room) begin
                        wr_en     = 1'b1;
                        state_nxt = eop ? ST_IDLE : ST_PASS;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = eop ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    orphan_inc = 1'b1;
                end
            end
            ST_PASS: if (beat) begin
                if (!full) begin
                    wr_en = 1'b1;
                    if (eop) state_nxt = ST_IDLE;
                end else begin
                    trunc_inc = 1'b1;
                    pend_nxt  = eop;
                    state_nxt = ST_TRUNC;
                end
            end
            ST_TRUNC: begin
                // An eop arriving in the same cycle as the terminator still ends the packet.
                if (!full) begin
                    wr_en     = 1'b1;
                    wr_word   = TERM_WORD;
                    pend_nxt  = 1'b0;
                    state_nxt = (pend_eop || (beat && eop)) ? ST_IDLE : ST_DROP;
                end else if (beat && eop) begin
                    pend_nxt = 1'b1;
                end
            end
            ST_DROP: if (beat) begin
                if (sop && !eop) begin
                    if (has_room) begin
                        wr_en     = 1'b1;
                        state_nxt = ST_PASS;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end else if (eop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            pend_eop <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            pend_eop <= pend_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count, which keeps the array RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    assign m_tvalid = (count != '0);
    assign rd_en    = m_tvalid & m_tready;
    assign rd_word  = m_tvalid ? mem[rd_ptr] : '0;
    assign m_tdata  = rd_word.data;
    assign m_tkeep  = rd_word.keep;
    assign m_tuser  = rd_word.user;
    assign m_tlast  = rd_word.last;

endmodule

// File: rtl/dcmac_rx_seg_buf.sv
// DCMAC rx segment buffer top: one admission-controlled FIFO lane per segment
// plus saturating drop/truncate/orphan counters shared across all lanes.
module dcmac_rx_seg_buf
    import dcmac_rx_pkg::*;
#(
    parameter int NUM_SEG     = 4,
    parameter int SEG_BYTES   = 16,
    parameter int FIFO_DEPTH  = 512,
    parameter int DROP_MARGIN = 8,
    parameter int CNT_WIDTH   = 32,
    localparam int MW         = $clog2(SEG_BYTES)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           valid,
    input  logic [NUM_SEG*SEG_BYTES*8-1:0] data,
    input  logic [NUM_SEG-1:0]             ena,
    input  logic [NUM_SEG-1:0]             sop,
    input  logic [NUM_SEG-1:0]             eop,
    input  logic [NUM_SEG-1:0]             err,
    input  logic [NUM_SEG*MW-1:0]          mty,
    output logic [NUM_SEG*SEG_BYTES*8-1:0] m_tdata,
    output logic [NUM_SEG*SEG_BYTES-1:0]   m_tkeep,
    output logic [NUM_SEG*TUSER_W-1:0]     m_tuser,
    output logic [NUM_SEG-1:0]             m_tlast,
    output logic [NUM_SEG-1:0]             m_tvalid,
    input  logic [NUM_SEG-1:0]             m_tready,
    input  logic                           stats_clear,
    output logic [CNT_WIDTH-1:0]           drop_cnt,
    output logic [CNT_WIDTH-1:0]           trunc_cnt,
    output logic [CNT_WIDTH-1:0]           orphan_cnt
);

    localparam int DW = SEG_BYTES * 8;
    localparam int IW = $clog2(NUM_SEG + 1);

    logic [NUM_SEG-1:0] drop_inc, trunc_inc, orphan_inc;

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_lane
        dcmac_rx_lane #(
            .SEG_BYTES  (SEG_BYTES),
            .FIFO_DEPTH (FIFO_DEPTH),
            .DROP_MARGIN(DROP_MARGIN)
        ) u_lane (
            .clk       (clk),
            .resetn    (resetn),
            .beat      (valid & ena[i]),
            .data      (data[i*DW +: DW]),
            .sop       (sop[i]),
            .eop       (eop[i]),
            .err       (err[i]),
            .mty       (mty[i*MW +: MW]),
            .m_tdata   (m_tdata[i*DW +: DW]),
            .m_tkeep   (m_tkeep[i*SEG_BYTES +: SEG_BYTES]),
            .m_tuser   (m_tuser[i*TUSER_W +: TUSER_W]),
            .m_tlast   (m_tlast[i]),
            .m_tvalid  (m_tvalid[i]),
            .m_tready  (m_tready[i]),
            .drop_inc  (drop_inc[i]),
            .trunc_inc (trunc_inc[i]),
            .orphan_inc(orphan_inc[i])
        );
    end

    // Index 0: drop, 1: trunc, 2: orphan.
    logic [NUM_SEG-1:0]   inc_vec [3];
    logic [IW-1:0]        inc_sum [3];
    logic [CNT_WIDTH:0]   sum_ext [3];
    logic [CNT_WIDTH-1:0] cnt_q   [3];
    logic [CNT_WIDTH-1:0] cnt_nxt [3];

    assign inc_vec[0] = drop_inc;
    assign inc_vec[1] = trunc_inc;
    assign inc_vec[2] = orphan_inc;

    // Add every lane's pulse in one step; the extra carry bit flags saturation.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            inc_sum[k] = '0;
            for (int i = 0; i < NUM_SEG; i++) begin
                inc_sum[k] = inc_sum[k] + IW'(inc_vec[k][i]);
            end
            sum_ext[k] = {1'b0, cnt_q[k]} + (CNT_WIDTH + 1)'(inc_sum[k]);
            cnt_nxt[k] = sum_ext[k][CNT_WIDTH] ? '1 : sum_ext[k][CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else if (stats_clear) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_nxt[k];
        end
    end

    assign drop_cnt   = cnt_q[0];
    assign trunc_cnt  = cnt_q[1];
    assign orphan_cnt = cnt_q[2];

endmodule

// File: tb/tb_dcmac_rx_seg_buf.sv
// Self-checking bench for dcmac_rx_seg_buf: directed stimulus pushes expected beats
// per lane into queues; a negedge monitor pops and compares on every output transfer.
module tb_dcmac_rx_seg_buf;

    localparam int NS    = 4;
    localparam int SB    = 16;
    localparam int DEPTH = 512;
    localparam int MARG  = 8;
    localparam int CNT_W = 4;
    localparam int DW    = SB * 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SB-1:0] keep;
        logic [2:0]    user;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              valid = 1'b0;
    logic [NS*DW-1:0]  data = '0;
    logic [NS-1:0]     ena = '0, sop = '0, eop = '0, err = '0;
    logic [NS*4-1:0]   mty = '0;
    logic [NS*DW-1:0]  m_tdata;
    logic [NS*SB-1:0]  m_tkeep;
    logic [NS*3-1:0]   m_tuser;
    logic [NS-1:0]     m_tlast, m_tvalid;
    logic [NS-1:0]     m_tready = '1;
    logic              stats_clear = 1'b0;
    logic [CNT_W-1:0]  drop_cnt, trunc_cnt, orphan_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [NS][$];

    dcmac_rx_seg_buf #(
        .NUM_SEG(NS), .SEG_BYTES(SB), .FIFO_DEPTH(DEPTH), .DROP_MARGIN(MARG), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .data(data), .ena(ena), .sop(sop),
        .eop(eop), .err(err), .mty(mty), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .stats_clear(stats_clear), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt),
        .orphan_cnt(orphan_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int l, input int idx);
        return {4{8'(l), 24'(idx)}};
    endfunction

    // Monitor: every accepted output beat must match the head of that lane's queue.
    always @(negedge clk) begin
        if (resetn) begin
            for (int l = 0; l < NS; l++) begin
                if (m_tvalid[l] && m_tready[l]) begin
                    beat_t got;
                    got = {m_tdata[l*DW +: DW], m_tkeep[l*SB +: SB], m_tuser[l*3 +: 3], m_tlast[l]};
                    if (exp_q[l].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d unexpected beat: got %h expected none", l, got);
                    end else begin
                        check($sformatf("lane%0d beat", l), 160'(got), 160'(exp_q[l].pop_front()));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        valid = 1'b0; ena = '0; sop = '0; eop = '0; err = '0; mty = '0; data = '0;
        stats_clear = 1'b0;
    endtask

    task automatic drive_lane(input int l, input logic s, input logic e, input logic er,
                              input logic [3:0] m, input logic [DW-1:0] d);
        valid = 1'b1;
        ena[l] = 1'b1; sop[l] = s; eop[l] = e; err[l] = er;
        mty[l*4 +: 4] = m;
        data[l*DW +: DW] = d;
    endtask

    // n beats, sop on first, eop/mty_last/err_last on last; the first n_wr are expected out.
    task automatic send_pkt(input int l, input int base, input int n, input int n_wr,
                            input logic [3:0] mty_last, input logic err_last);
        for (int i = 0; i < n; i++) begin
            logic s, e, er;
            logic [3:0] m;
            logic [SB-1:0] k;
            s  = (i == 0);
            e  = (i == n - 1);
            m  = e ? mty_last : 4'd0;
            er = e & err_last;
            k  = 16'hFFFF >> m;
            drive_lane(l, s, e, er, m, mkdata(l, base + i));
            if (i < n_wr) exp_q[l].push_back({mkdata(l, base + i), k, {er, s, 1'b1}, e});
            tick();
        end
    endtask

    task automatic wait_drain(input int l, input int budget);
        int n;
        n = 0;
        while (exp_q[l].size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check($sformatf("lane%0d drain remaining", l), 160'(exp_q[l].size()), 160'(0));
    endtask

    task automatic check_cnts(input string tag, input int d, input int t, input int o);
        check({tag, " drop_cnt"}, 160'(drop_cnt), 160'(d));
        check({tag, " trunc_cnt"}, 160'(trunc_cnt), 160'(t));
        check({tag, " orphan_cnt"}, 160'(orphan_cnt), 160'(o));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset m_tvalid", 160'(m_tvalid), 160'(0));
        check("reset m_tdata", 160'(m_tdata[DW-1:0]), 160'(0));
        check_cnts("reset", 0, 0, 0);
        resetn = 1'b1;
        tick();

        // 3-beat packet on lane 2, mty 5 on eop -> last tkeep 16'h07FF.
        send_pkt(2, 0, 3, 3, 4'd5, 1'b0);
        wait_drain(2, 50);
        for (int l = 0; l < NS; l++)
            if (l != 2) check($sformatf("lane%0d idle", l), 160'(exp_q[l].size()), 160'(0));

        // Lane 0 blocked: fill to free == margin, admit one beat, then a packet is dropped.
        m_tready = 4'b1110;
        send_pkt(0, 100, DEPTH - MARG, DEPTH - MARG, 4'd0, 1'b0);
        send_pkt(0, 1000, 1, 1, 4'd3, 1'b0);
        send_pkt(0, 2000, 4, 0, 4'd0, 1'b0);
        check_cnts("drop", 1, 0, 0);
        m_tready = 4'b1111;
        wait_drain(0, 700);
        send_pkt(0, 3000, 2, 2, 4'd7, 1'b0);
        wait_drain(0, 50);

        // Lane 1 blocked: 600-beat packet truncates at 512 stored beats, then a terminator.
        m_tready = 4'b1101;
        send_pkt(1, 4000, 600, DEPTH, 4'd0, 1'b0);
        check_cnts("trunc", 1, 1, 0);
        exp_q[1].push_back({{DW{1'b0}}, {SB{1'b0}}, 3'b101, 1'b1});
        m_tready = 4'b1111;
        wait_drain(1, 700);
        send_pkt(1, 5000, 3, 3, 4'd2, 1'b1);
        wait_drain(1, 50);

        // Orphan on lane 3, single-beat packet stays IDLE so the next non-sop beat is orphaned too.
        drive_lane(3, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(3, 1));
        tick();
        check_cnts("orphan1", 1, 1, 1);
        send_pkt(3, 6000, 1, 1, 4'd15, 1'b1);
        drive_lane(3, 1'b0, 1'b1, 1'b0, 4'd0, mkdata(3, 2));
        tick();
        check_cnts("orphan2", 1, 1, 2);
        wait_drain(3, 50);

        // Multi-lane increments and saturation of the 4-bit orphan counter.
        for (int l = 0; l < NS; l++) drive_lane(l, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(l, 7));
        tick();
        check_cnts("orphan4a", 1, 1, 6);
        for (int l = 0; l < NS; l++) drive_lane(l, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(l, 8));
        tick();
        for (int l = 0; l < 3; l++) drive_lane(l, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(l, 9));
        tick();
        check_cnts("orphan13", 1, 1, 13);
        for (int l = 0; l < NS; l++) drive_lane(l, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(l, 10));
        tick();
        check_cnts("saturate", 1, 1, 15);
        for (int l = 0; l < NS; l++) drive_lane(l, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(l, 11));
        stats_clear = 1'b1;
        tick();
        check_cnts("clear", 0, 0, 0);

        // Reset mid-packet with data held in lanes 0 and 2.
        m_tready = 4'b0000;
        drive_lane(0, 1'b1, 1'b0, 1'b0, 4'd0, mkdata(0, 20));
        drive_lane(2, 1'b1, 1'b0, 1'b0, 4'd0, mkdata(2, 20));
        drive_lane(3, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(3, 20));
        tick();
        drive_lane(0, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(0, 21));
        tick();
        check("pre-reset m_tvalid", 160'(m_tvalid), 160'(4'b0101));
        check_cnts("pre-reset", 0, 0, 1);
        resetn = 1'b0;
        #1;
        check("async reset m_tvalid", 160'(m_tvalid), 160'(0));
        check("async reset m_tdata", 160'(m_tdata), 160'(0));
        check("async reset m_tuser", 160'(m_tuser), 160'(0));
        check_cnts("async reset", 0, 0, 0);
        for (int l = 0; l < NS; l++) exp_q[l].delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        m_tready = 4'b1111;
        drive_lane(0, 1'b0, 1'b0, 1'b0, 4'd0, mkdata(0, 22));
        tick();
        drive_lane(0, 1'b0, 1'b1, 1'b0, 4'd4, mkdata(0, 23));
        tick();
        check_cnts("post-reset", 0, 0, 2);
        send_pkt(0, 8000, 2, 2, 4'd1, 1'b0);
        send_pkt(2, 8100, 1, 1, 4'd0, 1'b0);
        wait_drain(0, 50);
        wait_drain(2, 50);

        for (int l = 0; l < NS; l++)
            check($sformatf("final lane%0d queue", l), 160'(exp_q[l].size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
